// File: rtl/led_fade_driver.sv
// led_fade_driver: turns each request bit into a PWM-dimmed LED that fades up/down in steps.
// Optional build macro LED_FADE_GAMMA_EN squares the level into the duty (one extra cycle).
module led_fade_driver #(
  parameter int unsigned N_LEDS   = 3,
  parameter int unsigned PWM_BITS = 8,
  parameter int unsigned STEP_DIV = 61
) (
  input  logic              sys_clk,
  input  logic              sys_rst,
  input  logic              enable,
  input  logic [N_LEDS-1:0] led_req,
  output logic [N_LEDS-1:0] led_out,
  output logic              settled
);

  localparam int unsigned         STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
  localparam int unsigned         SQ_W      = 2 * PWM_BITS;
  localparam logic [PWM_BITS-1:0] LVL_MAX   = {PWM_BITS{1'b1}};
  localparam logic [STEP_W-1:0]   STEP_LAST = STEP_W'(STEP_DIV - 1);

  typedef enum logic [1:0] {S_OFF, S_RISE, S_ON, S_FALL} fade_state_e;

  logic [PWM_BITS-1:0] pwm_cnt;
  logic [STEP_W-1:0]   step_cnt;
  logic [N_LEDS-1:0]   req_q;
  logic                period_end;
  logic                step;
  logic                all_stable;
  logic [N_LEDS-1:0]   hold;
  fade_state_e         state   [N_LEDS];
  logic [PWM_BITS-1:0] level   [N_LEDS];
  logic [PWM_BITS-1:0] lvl_inc [N_LEDS];
  logic [PWM_BITS-1:0] lvl_dec [N_LEDS];
  logic [PWM_BITS-1:0] duty    [N_LEDS];

  // Shared timing strobes and per-channel next-level candidates
  always_comb begin
    period_end = enable && (pwm_cnt == LVL_MAX);
    step       = period_end && (step_cnt == STEP_LAST);
    all_stable = 1'b1;
    for (int i = 0; i < N_LEDS; i++) begin
      lvl_inc[i] = level[i] + 1'b1;
      lvl_dec[i] = level[i] - 1'b1;
      hold[i]    = ((state[i] == S_OFF) && !req_q[i]) || ((state[i] == S_ON) && req_q[i]);
      if ((state[i] == S_RISE) || (state[i] == S_FALL)) all_stable = 1'b0;
    end
  end

  // Request capture, PWM counter and fade-step prescaler
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      req_q    <= '0;
      pwm_cnt  <= '0;
      step_cnt <= '0;
    end else begin
      req_q <= led_req;
      if (enable) pwm_cnt <= pwm_cnt + 1'b1;
      if (period_end) step_cnt <= (step_cnt == STEP_LAST) ? '0 : step_cnt + 1'b1;
    end
  end

  // Fade FSMs: any move that lands on an endpoint parks the channel there,
  // so a reversal right next to 0 or MAX never carries level out of range.
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < N_LEDS; i++) begin
        state[i] <= S_OFF;
        level[i] <= '0;
      end
    end else if (step) begin
      for (int i = 0; i < N_LEDS; i++) begin
        if (!hold[i]) begin
          if (req_q[i]) begin
            level[i] <= lvl_inc[i];
            state[i] <= (lvl_inc[i] == LVL_MAX) ? S_ON : S_RISE;
          end else begin
            level[i] <= lvl_dec[i];
            state[i] <= (lvl_dec[i] == '0) ? S_OFF : S_FALL;
          end
        end
      end
    end
  end

`ifdef LED_FADE_GAMMA_EN
  logic [SQ_W-1:0] lvl_sq [N_LEDS];

  always_comb begin
    for (int i = 0; i < N_LEDS; i++) lvl_sq[i] = SQ_W'(level[i]) * SQ_W'(level[i]);
  end

  // Squared duty; full brightness is forced so MAX still means always-on
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      for (int i = 0; i < N_LEDS; i++) duty[i] <= '0;
    end else begin
      for (int i = 0; i < N_LEDS; i++)
        duty[i] <= (level[i] == LVL_MAX) ? LVL_MAX : lvl_sq[i][SQ_W-1:PWM_BITS];
    end
  end
`else
  always_comb begin
    for (int i = 0; i < N_LEDS; i++) duty[i] = level[i];
  end
`endif

  // Registered pad drive and settled flag
  always_ff @(posedge sys_clk or posedge sys_rst) begin
    if (sys_rst) begin
      led_out <= '0;
      settled <= 1'b1;
    end else begin
      for (int i = 0; i < N_LEDS; i++)
        led_out[i] <= enable && ((duty[i] == LVL_MAX) || (pwm_cnt < duty[i]));
      settled <= all_stable;
    end
  end

endmodule

// File: tb/tb_led_fade_driver.sv
// Bench for led_fade_driver at PWM_BITS=3, STEP_DIV=2; define LED_FADE_GAMMA_EN
// for the build to check the gamma variant.
module tb_led_fade_driver;

  localparam int unsigned N     = 3;
  localparam int unsigned PB    = 3;
  localparam int unsigned SD    = 2;
  localparam int          MAXV  = 7;
  localparam int          PER   = 8;
  localparam int          STEPC = PER * SD;

  logic         sys_clk = 1'b0;
  logic         sys_rst;
  logic         enable;
  logic [N-1:0] led_req;
  logic [N-1:0] led_out;
  logic         settled;

  int checks = 0;
  int errors = 0;

  // Reference model: brightness walks one unit per fade step toward the request
  int           m_level  [N];
  int           m_duty_q [N];
  int           m_run;
  logic [N-1:0] m_req_q;
  logic [N-1:0] m_out;
  logic         m_settled;

  typedef struct {
    logic [N-1:0] req;
    logic         en;
    int           cycles;
    logic [N-1:0] exp_out;
    logic         exp_settled;
  } vec_t;

  vec_t vecs [8];

  always #5 sys_clk = ~sys_clk;

  led_fade_driver #(.N_LEDS(N), .PWM_BITS(PB), .STEP_DIV(SD)) dut (
    .sys_clk (sys_clk),
    .sys_rst (sys_rst),
    .enable  (enable),
    .led_req (led_req),
    .led_out (led_out),
    .settled (settled)
  );

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0t actual=%0h expected=%0h", name, $time, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    checks++;
    errors++;
    $display("FAIL %s t=%0t actual=timeout expected=reached", name, $time);
  endtask

  function automatic int gamma_duty(input int lvl);
    if (lvl == MAXV) return MAXV;
    return (lvl * lvl) >> PB;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N; i++) begin
      m_level[i]  = 0;
      m_duty_q[i] = 0;
    end
    m_run     = 0;
    m_req_q   = '0;
    m_out     = '0;
    m_settled = 1'b1;
  endtask

  // Advance model and DUT one clock, then compare outputs
  task automatic tick();
    int           pwm;
    int           duty;
    int           lvl_n;
    bit           stp;
    logic [N-1:0] out_n;
    logic         set_n;
    pwm   = m_run % PER;
    stp   = enable && ((m_run % STEPC) == STEPC - 1);
    set_n = 1'b1;
    for (int i = 0; i < N; i++) begin
`ifdef LED_FADE_GAMMA_EN
      duty = m_duty_q[i];
`else
      duty = m_level[i];
`endif
      out_n[i] = enable && ((duty == MAXV) || (pwm < duty));
      if ((m_level[i] != 0) && (m_level[i] != MAXV)) set_n = 1'b0;
      lvl_n = m_level[i];
      if (stp) begin
        if (m_req_q[i] && (m_level[i] < MAXV)) lvl_n = lvl_n + 1;
        else if (!m_req_q[i] && (m_level[i] > 0)) lvl_n = lvl_n - 1;
      end
      m_duty_q[i] = gamma_duty(m_level[i]);
      m_level[i]  = lvl_n;
    end
    m_req_q   = led_req;
    if (enable) m_run = m_run + 1;
    m_out     = out_n;
    m_settled = set_n;
    @(posedge sys_clk);
    #1;
    check("led_out", int'(led_out), int'(m_out));
    check("settled", int'(settled), int'(m_settled));
  endtask

  task automatic wait_level(input int ch, input int lvl, input int budget);
    int n = 0;
    while ((m_level[ch] != lvl) && (n < budget)) begin
      tick();
      n++;
    end
    if (m_level[ch] != lvl) timeout($sformatf("wait_level_ch%0d_%0d", ch, lvl));
  endtask

  task automatic align_step();
    int n = 0;
    while (((m_run % STEPC) != 0) && (n < STEPC)) begin
      tick();
      n++;
    end
    if ((m_run % STEPC) != 0) timeout("align_step");
  endtask

  task automatic count_highs(input int ch, input int n, output int highs);
    highs = 0;
    for (int k = 0; k < n; k++) begin
      tick();
      if (led_out[ch]) highs++;
    end
  endtask

  initial begin
    int highs;
    int n;

    vecs[0] = '{req: 3'b000, en: 1'b1, cycles: 200, exp_out: 3'b000, exp_settled: 1'b1};
    vecs[1] = '{req: 3'b001, en: 1'b1, cycles: 200, exp_out: 3'b001, exp_settled: 1'b1};
    vecs[2] = '{req: 3'b000, en: 1'b1, cycles: 200, exp_out: 3'b000, exp_settled: 1'b1};
    vecs[3] = '{req: 3'b010, en: 1'b0, cycles: 50,  exp_out: 3'b000, exp_settled: 1'b1};
    vecs[4] = '{req: 3'b010, en: 1'b1, cycles: 200, exp_out: 3'b010, exp_settled: 1'b1};
    vecs[5] = '{req: 3'b111, en: 1'b1, cycles: 200, exp_out: 3'b111, exp_settled: 1'b1};
    vecs[6] = '{req: 3'b101, en: 1'b0, cycles: 30,  exp_out: 3'b000, exp_settled: 1'b1};
    vecs[7] = '{req: 3'b101, en: 1'b1, cycles: 200, exp_out: 3'b101, exp_settled: 1'b1};

    sys_rst = 1'b0;
    enable  = 1'b1;
    led_req = '0;
    #2;
    sys_rst = 1'b1;
    #1;
    check("reset_led_out", int'(led_out), 0);
    check("reset_settled", int'(settled), 1);
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset_hold_led_out", int'(led_out), 0);
    check("reset_hold_settled", int'(settled), 1);
    sys_rst = 1'b0;
    model_reset();

    // Table of held request/enable patterns, each checked at its end
    for (int v = 0; v < 8; v++) begin
      led_req = vecs[v].req;
      enable  = vecs[v].en;
      for (int c = 0; c < vecs[v].cycles; c++) tick();
      check($sformatf("vec%0d_led_out", v), int'(led_out), int'(vecs[v].exp_out));
      check($sformatf("vec%0d_settled", v), int'(settled), int'(vecs[v].exp_settled));
    end

    // Reversal from ON: three falling steps to level 4, then back up to ON
    align_step();
    led_req = 3'b000;
    repeat (48) tick();
    led_req = 3'b001;
`ifdef LED_FADE_GAMMA_EN
    count_highs(0, 8, highs);
    check("reversal_duty_lvl4", highs, 2);
`else
    count_highs(0, 8, highs);
    check("reversal_duty_lvl4", highs, 4);
`endif
    wait_level(0, MAXV, 120);
    repeat (4) tick();
    count_highs(0, 16, highs);
    check("on_constant_high", highs, 16);
    check("on_settled", int'(settled), 1);

    // Freeze at level 5 while falling, then resume with the same duty
    led_req = 3'b000;
    wait_level(0, 5, 80);
    enable = 1'b0;
    tick();
    check("disable_led_out", int'(led_out), 0);
    repeat (49) tick();
    enable = 1'b1;
    count_highs(0, 8, highs);
`ifdef LED_FADE_GAMMA_EN
    check("resume_duty_lvl5", highs, 3);
`else
    check("resume_duty_lvl5", highs, 5);
`endif

    // Asynchronous reset mid-fade with ch0 and ch2 rising at level 4
    wait_level(0, 0, 120);
    wait_level(2, 0, 120);
    led_req = 3'b101;
    wait_level(0, 4, 120);
    n = 0;
    while ((m_out[0] != 1'b1) && (n < PER)) begin
      tick();
      n++;
    end
    if (m_out[0] != 1'b1) timeout("wait_out_high");
    #2;
    sys_rst = 1'b1;
    #1;
    check("midfade_rst_led_out", int'(led_out), 0);
    check("midfade_rst_settled", int'(settled), 1);
    #2;
    led_req = 3'b000;
    sys_rst = 1'b0;
    model_reset();
    tick();
    check("post_rst_led_out", int'(led_out), 0);
    check("post_rst_settled", int'(settled), 1);
    repeat (40) tick();
    check("post_rst_idle_out", int'(led_out), 0);

    // Random request/enable bursts against the model
    for (int s = 0; s < 60; s++) begin
      led_req = N'($urandom_range(0, 7));
      enable  = ($urandom_range(0, 9) != 0);
      n       = int'($urandom_range(1, 60));
      for (int c = 0; c < n; c++) tick();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
